// File: rtl/led_serial_encoder_pkg.sv
// rtl/led_serial_encoder_pkg.sv - shared types and default timings for the LED single-wire transmit path
//
// Contents:
//   led_tx_state_e  encoder FSM states {IDLE, HIGH, LOW, LATCH}
//   led_tx_word_t   one accepted pixel word with its end-of-frame marker
//   *_DEF           default bit and latch timings in clock cycles; the receive
//                   side derives its decode threshold from the same values
package led_serial_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } led_tx_state_e;

    typedef struct packed {
        logic [23:0] pixel;
        logic        last;
    } led_tx_word_t;

    localparam int T0H_DEF    = 20;
    localparam int T1H_DEF    = 40;
    localparam int TBIT_DEF   = 63;
    localparam int TRESET_DEF = 2500;

endpackage

// File: rtl/led_serial_encoder_phase_timer.sv
// rtl/led_serial_encoder_phase_timer.sv - loadable down-counter timing the HIGH, LOW and LATCH phases
//
// Module led_phase_timer. Loading value N makes tc_o assert N cycles later,
// so a phase lasting D cycles is loaded with D-1 on the edge that enters it.
// Ports:
//   clk_i      clock
//   rst_i      synchronous reset, active-high; clears the count
//   load_i     load value_i on this edge (has priority over counting)
//   value_i    load value
//   tc_o       terminal count: the count is zero
module led_phase_timer #(
    parameter int CWIDTH = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CWIDTH-1:0] value_i,
    output logic              tc_o
);

    logic [CWIDTH-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/led_serial_encoder.sv
// rtl/led_serial_encoder.sv - single-wire NRZ pulse-width LED transmitter with frame latch
//
// Accepts 24-bit pixel words (bit 23 first) over valid/ready and drives a
// short high pulse for 0 bits and a long one for 1 bits, each bit TBIT cycles.
// After a word flagged last the line is held low for TRESET cycles and o_done
// pulses on the final latch cycle.
// Build option: LED_TX_PREFETCH_EN adds a one-entry holding buffer so that
// consecutive words are sent with no gap; without it the encoder only accepts
// in IDLE and each following word costs one extra low cycle.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_pixel, i_last     word and end-of-frame flag, qualified by i_valid
//   i_valid, o_ready    handshake; transfer when both are high
//   o_serial            encoded line (registered)
//   o_busy              a word or latch is in progress
//   o_done              one-cycle pulse on the last latch cycle
module led_serial_encoder
    import led_serial_encoder_pkg::*;
#(
    parameter int T0H    = T0H_DEF,
    parameter int T1H    = T1H_DEF,
    parameter int TBIT   = TBIT_DEF,
    parameter int TRESET = TRESET_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_pixel,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_done
);

    localparam int CWIDTH = $clog2(((TBIT > TRESET) ? TBIT : TRESET) + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_HIGH  = HIGH;
    localparam logic [1:0] S_LOW   = LOW;
    localparam logic [1:0] S_LATCH = LATCH;

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_bit_timing
        $fatal(1, "led_serial_encoder: bit timing must satisfy 0 < T0H < T1H < TBIT");
    end
    if (TRESET < TBIT) begin : g_bad_latch_timing
        $fatal(1, "led_serial_encoder: TRESET must be at least TBIT");
    end

    // Timer load values are one less than the phase length (see led_phase_timer).
    function automatic logic [CWIDTH-1:0] high_load(input logic b);
        return b ? CWIDTH'(T1H - 1) : CWIDTH'(T0H - 1);
    endfunction

    function automatic logic [CWIDTH-1:0] low_load(input logic b);
        return b ? CWIDTH'(TBIT - T1H - 1) : CWIDTH'(TBIT - T0H - 1);
    endfunction

    logic [1:0]        state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [4:0]        idx_q, idx_d;
    logic              last_q, last_d;
    logic              serial_q;

    logic              tmr_load;
    logic [CWIDTH-1:0] tmr_value;
    logic              tmr_tc;

    logic              ready;
    logic              xfer;
    logic              have_next;
    led_tx_word_t      next_word;
    logic              start_word;
    logic              done;

    led_phase_timer #(
        .CWIDTH (CWIDTH)
    ) u_timer (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .tc_o    (tmr_tc)
    );

`ifdef LED_TX_PREFETCH_EN
    led_tx_word_t buf_q, buf_d;
    logic         buf_valid_q, buf_valid_d;

    assign ready     = !i_reset && !buf_valid_q && (state_q != S_LATCH);
    assign xfer      = i_valid && ready;
    // A buffered word always goes before a word arriving this cycle.
    assign have_next = buf_valid_q || xfer;
    assign next_word = buf_valid_q ? buf_q : '{pixel: i_pixel, last: i_last};

    always_comb begin
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        if (start_word && !xfer) begin
            buf_valid_d = 1'b0;
        end
        // A word not started directly parks in the buffer; this includes a
        // word arriving on the cycle the FSM enters LATCH.
        if (xfer && !start_word) begin
            buf_d       = '{pixel: i_pixel, last: i_last};
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end
`else
    assign ready     = !i_reset && (state_q == S_IDLE);
    assign xfer      = i_valid && ready;
    assign have_next = xfer;
    assign next_word = '{pixel: i_pixel, last: i_last};
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        last_d     = last_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        start_word = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (have_next) begin
                    start_word = 1'b1;
                end
            end
            S_HIGH: begin
                if (tmr_tc) begin
                    state_d   = S_LOW;
                    tmr_load  = 1'b1;
                    tmr_value = low_load(shift_q[23]);
                end
            end
            S_LOW: begin
                if (tmr_tc) begin
                    if (idx_q != 5'd0) begin
                        idx_d     = idx_q - 5'd1;
                        shift_d   = {shift_q[22:0], 1'b0};
                        state_d   = S_HIGH;
                        tmr_load  = 1'b1;
                        tmr_value = high_load(shift_q[22]);
                    end else if (last_q) begin
                        state_d   = S_LATCH;
                        tmr_load  = 1'b1;
                        tmr_value = CWIDTH'(TRESET - 1);
                    end else if (have_next) begin
                        start_word = 1'b1;
                    end else begin
                        // Underrun: idle with the line low; the source owns
                        // any resulting early latch.
                        state_d = S_IDLE;
                    end
                end
            end
            S_LATCH: begin
                if (tmr_tc) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_word) begin
            state_d   = S_HIGH;
            shift_d   = next_word.pixel;
            idx_d     = 5'd23;
            last_d    = next_word.last;
            tmr_load  = 1'b1;
            tmr_value = high_load(next_word.pixel[23]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            // Registered so the line never sees state-decode glitches.
            serial_q <= (state_d == S_HIGH);
        end
    end

    assign o_ready  = ready;
    assign o_serial = serial_q;
    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = done && !i_reset;

endmodule

// File: tb/tb_led_serial_encoder.sv
// tb/tb_led_serial_encoder.sv - randomized self-checking bench for led_serial_encoder
module tb_led_serial_encoder;

    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 10;
    localparam int WORD_CYC = 24 * TBIT;
`ifdef LED_TX_PREFETCH_EN
    localparam int GAP  = 0;
    localparam bit PREF = 1'b1;
`else
    localparam int GAP  = 1;
    localparam bit PREF = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [23:0] i_pixel = '0;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic        o_ready, o_serial, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    logic [23:0] frame_pix[$];
    logic exp_s[$], exp_b[$], exp_r[$], exp_d[$];
    logic rec_s[$], rec_b[$], rec_r[$], rec_d[$];

    always #5 i_clk = ~i_clk;

    led_serial_encoder #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TRESET (TRESET)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_pixel  (i_pixel),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .o_ready  (o_ready),
        .o_serial (o_serial),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    // Expected per-cycle outputs for frame_pix sent with valid held high;
    // index 0 is the cycle the first word is accepted.
    task automatic build_model();
        int n = frame_pix.size();
        exp_s = {}; exp_b = {}; exp_r = {}; exp_d = {};
        exp_s.push_back(0); exp_b.push_back(0); exp_r.push_back(1); exp_d.push_back(0);
        for (int w = 0; w < n; w++) begin
            for (int j = 0; j < WORD_CYC; j++) begin
                int hi = frame_pix[w][23 - j / TBIT] ? T1H : T0H;
                exp_s.push_back((j % TBIT) < hi);
                exp_b.push_back(1);
                exp_r.push_back(PREF ? ((j == 0) || (w == n - 1)) : 1'b0);
                exp_d.push_back(0);
            end
            if (w < n - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    exp_s.push_back(0); exp_b.push_back(0); exp_r.push_back(1); exp_d.push_back(0);
                end
            end
        end
        for (int t = 0; t < TRESET; t++) begin
            exp_s.push_back(0); exp_b.push_back(1); exp_r.push_back(0); exp_d.push_back(t == TRESET - 1);
        end
        for (int t = 0; t < 3; t++) begin
            exp_s.push_back(0); exp_b.push_back(0); exp_r.push_back(1); exp_d.push_back(0);
        end
    endtask

    // Drives frame_pix back-to-back and records outputs from the accept cycle.
    task automatic run_frame(output bit ok);
        int n = frame_pix.size();
        int wi = 0;
        bit pend = 0;
        bit started = 0;
        ok = 0;
        rec_s = {}; rec_b = {}; rec_r = {}; rec_d = {};
        i_valid = 1; i_pixel = frame_pix[0]; i_last = (n == 1);
        for (int c = 0; c < 2000; c++) begin
            if (pend) begin
                wi++;
                if (wi < n) begin
                    i_pixel = frame_pix[wi]; i_last = (wi == n - 1);
                end else begin
                    i_valid = 0; i_last = 0;
                end
                pend = 0;
            end
            if (!started && i_valid && o_ready) started = 1;
            if (started) begin
                rec_s.push_back(o_serial); rec_b.push_back(o_busy);
                rec_r.push_back(o_ready); rec_d.push_back(o_done);
                if (rec_s.size() == exp_s.size()) begin
                    ok = 1;
                    break;
                end
            end
            pend = i_valid && o_ready;
            @(negedge i_clk);
        end
        i_valid = 0; i_last = 0;
    endtask

    // Offers one word at the current negedge and returns on its accept cycle.
    task automatic offer_word(input logic [23:0] pix, input logic last, output bit ok);
        ok = 0;
        i_valid = 1; i_pixel = pix; i_last = last;
        for (int c = 0; c < 50; c++) begin
            if (o_ready) begin
                ok = 1;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        i_reset = 1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_serial !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: serial=%b busy=%b done=%b ready=%b, want all 0", o_serial, o_busy, o_done, o_ready);
        end
        i_reset = 0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", o_ready);
        end
        @(negedge i_clk);
    endtask

    task automatic test_frames();
        bit ok;
        for (int f = 0; f < 5; f++) begin
            int n = (f == 0) ? 1 : 1 + int'($urandom_range(2, 0));
            int fs = -1, fb = -1, fr = -1, fd = -1;
            logic dec_bits[$];
            int run = 0;
            frame_pix = {};
            if (f == 0) frame_pix.push_back(24'h800001);
            else for (int w = 0; w < n; w++) frame_pix.push_back(24'($urandom));
            build_model();
            run_frame(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL frame%0d_timeout: recorded %0d cycles want %0d", f, rec_s.size(), exp_s.size());
                continue;
            end
            for (int k = 0; k < rec_s.size(); k++) begin
                if (fs < 0 && rec_s[k] !== exp_s[k]) fs = k;
                if (fb < 0 && rec_b[k] !== exp_b[k]) fb = k;
                if (fr < 0 && rec_r[k] !== exp_r[k]) fr = k;
                if (fd < 0 && rec_d[k] !== exp_d[k]) fd = k;
            end
            checks++;
            if (fs >= 0) begin errors++; $display("FAIL frame%0d_serial: cycle %0d got %b want %b", f, fs, rec_s[fs], exp_s[fs]); end
            checks++;
            if (fb >= 0) begin errors++; $display("FAIL frame%0d_busy: cycle %0d got %b want %b", f, fb, rec_b[fb], exp_b[fb]); end
            checks++;
            if (fr >= 0) begin errors++; $display("FAIL frame%0d_ready: cycle %0d got %b want %b", f, fr, rec_r[fr], exp_r[fr]); end
            checks++;
            if (fd >= 0) begin errors++; $display("FAIL frame%0d_done: cycle %0d got %b want %b", f, fd, rec_d[fd], exp_d[fd]); end
            // Receiver view: classify each high pulse by width against the midpoint.
            for (int k = 0; k < rec_s.size(); k++) begin
                if (rec_s[k] === 1'b1) run++;
                else if (run > 0) begin
                    dec_bits.push_back(run * 2 > T0H + T1H);
                    run = 0;
                end
            end
            checks++;
            if (dec_bits.size() != 24 * n) begin
                errors++;
                $display("FAIL frame%0d_bitcount: got %0d want %0d", f, dec_bits.size(), 24 * n);
            end else begin
                for (int w = 0; w < n; w++) begin
                    logic [23:0] word = '0;
                    for (int b = 0; b < 24; b++) word = {word[22:0], dec_bits[w * 24 + b]};
                    checks++;
                    if (word !== frame_pix[w]) begin
                        errors++;
                        $display("FAIL frame%0d_word%0d_decode: got %06h want %06h", f, w, word, frame_pix[w]);
                    end
                end
            end
            if (f == 0) begin
                checks++;
                if (exp_d.size() < 155 || exp_d[154] !== 1'b1 || rec_d[154] !== 1'b1) begin
                    errors++;
                    $display("FAIL single_done_cycle154: got %b want 1", rec_d[154]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int rises[$];
        int fr = -1, fs = -1;
        frame_pix = {};
        frame_pix.push_back(24'($urandom));
        frame_pix.push_back(24'($urandom));
        build_model();
        run_frame(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: recorded %0d cycles want %0d", rec_s.size(), exp_s.size());
            return;
        end
        for (int k = 1; k < rec_s.size(); k++)
            if (rec_s[k] === 1'b1 && rec_s[k-1] !== 1'b1) rises.push_back(k);
        checks++;
        if (rises.size() != 48) begin
            errors++;
            $display("FAIL b2b_rise_count: got %0d want 48", rises.size());
        end else begin
            checks++;
            if (rises[24] - rises[0] != WORD_CYC + GAP) begin
                errors++;
                $display("FAIL b2b_gap: got %0d want %0d", rises[24] - rises[0], WORD_CYC + GAP);
            end
        end
        for (int k = 0; k < rec_s.size(); k++) begin
            if (fr < 0 && rec_r[k] !== exp_r[k]) fr = k;
            if (fs < 0 && rec_s[k] !== exp_s[k]) fs = k;
        end
        checks++;
        if (fr >= 0) begin errors++; $display("FAIL b2b_ready: cycle %0d got %b want %b", fr, rec_r[fr], exp_r[fr]); end
        checks++;
        if (fs >= 0) begin errors++; $display("FAIL b2b_serial: cycle %0d got %b want %b", fs, rec_s[fs], exp_s[fs]); end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        bit saw_done = 0, saw_high = 0;
        offer_word(24'($urandom) | 24'h800000, 1'b1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_accept: ready never seen, want 1");
            i_valid = 0;
            return;
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge i_clk);
            if (k == 1) begin i_valid = 0; i_last = 0; end
        end
        i_reset = 1;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready_in_reset: got %b want 0", o_ready); end
        @(negedge i_clk);
        checks++;
        if (o_serial !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_line: serial=%b busy=%b want 0 0", o_serial, o_busy);
        end
        i_reset = 0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready_after: got %b want 1", o_ready); end
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) saw_done = 1;
            if (o_serial === 1'b1) saw_high = 1;
        end
        checks++;
        if (saw_done || saw_high) begin
            errors++;
            $display("FAIL midreset_quiet: done_seen=%b high_seen=%b want 0 0", saw_done, saw_high);
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int fs = -1;
        bit saw_done = 0;
        logic s_at[$], b_at[$], r_at[$];
        offer_word(24'h000000, 1'b0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL underrun_accept: ready never seen, want 1");
            i_valid = 0;
            return;
        end
        s_at.push_back(o_serial); b_at.push_back(o_busy); r_at.push_back(o_ready);
        for (int k = 1; k <= 200; k++) begin
            @(negedge i_clk);
            if (k == 1) begin i_valid = 0; end
            s_at.push_back(o_serial); b_at.push_back(o_busy); r_at.push_back(o_ready);
            if (o_done === 1'b1) saw_done = 1;
        end
        for (int k = 1; k <= 200; k++) begin
            logic want = (k <= WORD_CYC) && (((k - 1) % TBIT) < T0H);
            if (fs < 0 && s_at[k] !== want) fs = k;
        end
        checks++;
        if (fs >= 0) begin errors++; $display("FAIL underrun_serial: cycle %0d got %b", fs, s_at[fs]); end
        checks++;
        if (b_at[WORD_CYC] !== 1'b1 || b_at[WORD_CYC + 1] !== 1'b0) begin
            errors++;
            $display("FAIL underrun_idle_time: busy at %0d,%0d got %b%b want 10", WORD_CYC, WORD_CYC + 1, b_at[WORD_CYC], b_at[WORD_CYC + 1]);
        end
        checks++;
        if (r_at[WORD_CYC + 1] !== 1'b1) begin errors++; $display("FAIL underrun_ready: got %b want 1", r_at[WORD_CYC + 1]); end
        checks++;
        if (saw_done) begin errors++; $display("FAIL underrun_no_done: got done pulse want none"); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_reset_mid_word();
        test_underrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
